// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/commit controller owning the CPU program counter.
// Sequences IMEM request, busywait, decode presentation, DMEM stall and PC commit.
module fetch_sequencer #(
  parameter int unsigned              PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]      RESET_PC     = '0,
  parameter int unsigned              IMEM_TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                RESET,
  output logic                IMEM_READ,
  input  logic                IMEM_BUSYWAIT,
  input  logic [PC_WIDTH-1:0] IMEM_INSTR,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] INSTRUCTION,
  output logic                INSTR_VALID,
  input  logic                BRANCH,
  input  logic                JUMP,
  input  logic                ZERO,
  input  logic [7:0]          RD_OFFSET,
  input  logic                DMEM_BUSYWAIT,
  output logic                FAULT
);

  localparam int unsigned CW = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(IMEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_EXEC      = 3'd2,
    S_MEM_STALL = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic                  read_q, read_d;
  logic                  fault_q, fault_d;
  logic                  first_q, first_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [PC_WIDTH-1:0]   offset_ext;
  logic [PC_WIDTH-1:0]   pc_plus4;
  logic [PC_WIDTH-1:0]   next_pc;

  always_comb begin
    offset_ext = {{(PC_WIDTH-8){RD_OFFSET[7]}}, RD_OFFSET};
    pc_plus4   = pc_q + PC_WIDTH'(4);
    next_pc    = (JUMP || (BRANCH && ZERO)) ? pc_plus4 + (offset_ext << 2) : pc_plus4;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    read_d  = read_q;
    fault_d = fault_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        read_d  = 1'b1;
        first_d = 1'b1;
        cnt_d   = '0;
      end
      S_FETCH: begin
        first_d = 1'b0;
        // busywait is not trusted on the first cycle, but a busy sample still counts toward timeout
        if (!first_q && !IMEM_BUSYWAIT) begin
          instr_d = IMEM_INSTR;
          valid_d = 1'b1;
          read_d  = 1'b0;
          state_d = S_EXEC;
        end else if (IMEM_BUSYWAIT) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            read_d  = 1'b0;
            valid_d = 1'b0;
          end
        end
      end
      S_EXEC, S_MEM_STALL: begin
        if (DMEM_BUSYWAIT) begin
          state_d = S_MEM_STALL;
        end else begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          read_d  = 1'b1;
          cnt_d   = '0;
          first_d = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FAULT: begin
        fault_d = 1'b1;
        read_d  = 1'b0;
        valid_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      read_q  <= 1'b0;
      fault_q <= 1'b0;
      first_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      read_q  <= read_d;
      fault_q <= fault_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
    end
  end

  assign IMEM_READ   = read_q;
  assign PC          = pc_q;
  assign INSTRUCTION = instr_q;
  assign INSTR_VALID = valid_q;
  assign FAULT       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: fetch timing, branch/jump targets, stalls, timeout, reset.
module tb_fetch_sequencer;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        IMEM_READ;
  logic        IMEM_BUSYWAIT = 1'b0;
  logic [31:0] IMEM_INSTR = '0;
  logic [31:0] PC;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic        BRANCH = 1'b0;
  logic        JUMP = 1'b0;
  logic        ZERO = 1'b0;
  logic [7:0]  RD_OFFSET = '0;
  logic        DMEM_BUSYWAIT = 1'b0;
  logic        FAULT;

  int errors = 0;
  int checks = 0;
  logic [31:0] pc_model = '0;

  fetch_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0), .IMEM_TIMEOUT(15)) dut (
    .CLK(CLK), .RESET(RESET), .IMEM_READ(IMEM_READ), .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
    .IMEM_INSTR(IMEM_INSTR), .PC(PC), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .BRANCH(BRANCH), .JUMP(JUMP), .ZERO(ZERO), .RD_OFFSET(RD_OFFSET),
    .DMEM_BUSYWAIT(DMEM_BUSYWAIT), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the DUT on its first FETCH cycle at RESET_PC.
  task automatic do_reset();
    RESET = 1'b0; IMEM_BUSYWAIT = 1'b0; DMEM_BUSYWAIT = 1'b0;
    BRANCH = 1'b0; JUMP = 1'b0; ZERO = 1'b0; RD_OFFSET = '0;
    step(); step();
    RESET = 1'b1;
    step();
    pc_model = 32'h0;
  endtask

  // From the first FETCH cycle to EXEC with `busy` busy samples.
  task automatic fetch(input int busy, input logic [31:0] instr);
    IMEM_INSTR = instr;
    if (busy == 0) begin
      IMEM_BUSYWAIT = 1'b0;
      step(); step();
    end else begin
      IMEM_BUSYWAIT = 1'b1;
      repeat (busy) step();
      IMEM_BUSYWAIT = 1'b0;
      step();
    end
  endtask

  task automatic commit(input logic b, input logic j, input logic z, input logic [7:0] off);
    BRANCH = b; JUMP = j; ZERO = z; RD_OFFSET = off; DMEM_BUSYWAIT = 1'b0;
    step();
    BRANCH = 1'b0; JUMP = 1'b0; ZERO = 1'b0; RD_OFFSET = '0;
  endtask

  // Reach `target` through a chain of jumps; bench tracks the PC itself.
  task automatic goto_pc(input logic [31:0] target);
    int delta;
    for (int i = 0; i < 20 && pc_model != target; i++) begin
      delta = $signed(target - pc_model - 32'd4) >>> 2;
      if (delta > 127) delta = 127;
      if (delta < -128) delta = -128;
      fetch(0, 32'hDEAD_0000);
      commit(1'b0, 1'b1, 1'b0, 8'(delta));
      pc_model = pc_model + 32'd4 + (32'(delta) << 2);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    step(); step();
    if (PC !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want %h", PC, 32'h0); end
    checks++;
    if ({IMEM_READ, INSTR_VALID, FAULT} !== 3'b000) begin
      errors++; $display("FAIL rst_flags: got %b want 000", {IMEM_READ, INSTR_VALID, FAULT});
    end
    checks++;
    if (INSTRUCTION !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", INSTRUCTION); end
    checks++;
  endtask

  task automatic test_first_fetch();
    IMEM_BUSYWAIT = 1'b1; IMEM_INSTR = 32'h0002_0105;
    RESET = 1'b1;
    step();
    if (IMEM_READ !== 1'b1 || PC !== 32'h0) begin
      errors++; $display("FAIL ff_read: got read=%b pc=%h want 1/0", IMEM_READ, PC);
    end
    checks++;
    repeat (3) step();
    if (INSTR_VALID !== 1'b0 || IMEM_READ !== 1'b1) begin
      errors++; $display("FAIL ff_busy: got valid=%b read=%b want 0/1", INSTR_VALID, IMEM_READ);
    end
    checks++;
    IMEM_BUSYWAIT = 1'b0;
    step();
    if (INSTRUCTION !== 32'h0002_0105 || INSTR_VALID !== 1'b1 || IMEM_READ !== 1'b0) begin
      errors++; $display("FAIL ff_latch: got instr=%h valid=%b read=%b want 00020105/1/0",
                         INSTRUCTION, INSTR_VALID, IMEM_READ);
    end
    checks++;
    commit(1'b0, 1'b0, 1'b0, 8'h00);
    if (PC !== 32'h4 || INSTR_VALID !== 1'b0 || IMEM_READ !== 1'b1) begin
      errors++; $display("FAIL ff_commit: got pc=%h valid=%b read=%b want 4/0/1", PC, INSTR_VALID, IMEM_READ);
    end
    checks++;
    pc_model = 32'h4;
  endtask

  task automatic test_branch();
    goto_pc(32'h10);
    if (PC !== 32'h10) begin errors++; $display("FAIL br_setup: got %h want 10", PC); end
    checks++;
    fetch(1, 32'h1111_0000);
    commit(1'b1, 1'b0, 1'b1, 8'hFE);
    if (PC !== 32'h0C) begin errors++; $display("FAIL br_taken: got %h want 0c", PC); end
    checks++;
    pc_model = 32'h0C;
    goto_pc(32'h10);
    fetch(2, 32'h2222_0000);
    commit(1'b1, 1'b0, 1'b0, 8'hFE);
    if (PC !== 32'h14) begin errors++; $display("FAIL br_not_taken: got %h want 14", PC); end
    checks++;
    pc_model = 32'h14;
  endtask

  task automatic test_jump();
    goto_pc(32'h20);
    fetch(0, 32'h3333_0000);
    commit(1'b0, 1'b1, 1'b0, 8'h03);
    if (PC !== 32'h30) begin errors++; $display("FAIL jmp_fwd: got %h want 30", PC); end
    checks++;
    pc_model = 32'h30;
    goto_pc(32'h400);
    if (PC !== 32'h400) begin errors++; $display("FAIL jmp_setup: got %h want 400", PC); end
    checks++;
    fetch(0, 32'h4444_0000);
    commit(1'b0, 1'b1, 1'b1, 8'h80);
    if (PC !== 32'h204) begin errors++; $display("FAIL jmp_min: got %h want 204", PC); end
    checks++;
    pc_model = 32'h204;
  endtask

  task automatic test_mem_stall();
    goto_pc(32'h08);
    fetch(0, 32'h5555_0000);
    DMEM_BUSYWAIT = 1'b1;
    JUMP = 1'b1; RD_OFFSET = 8'h05;
    for (int i = 0; i < 3; i++) begin
      step();
      if (PC !== 32'h08 || INSTR_VALID !== 1'b1 || IMEM_READ !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d: got pc=%h valid=%b read=%b want 08/1/0",
                           i, PC, INSTR_VALID, IMEM_READ);
      end
      checks++;
    end
    commit(1'b0, 1'b0, 1'b0, 8'h00);
    if (PC !== 32'h0C || IMEM_READ !== 1'b1 || INSTR_VALID !== 1'b0) begin
      errors++; $display("FAIL stall_commit: got pc=%h read=%b valid=%b want 0c/1/0", PC, IMEM_READ, INSTR_VALID);
    end
    checks++;
    fetch(0, 32'h6666_0000);
    commit(1'b1, 1'b1, 1'b0, 8'h01);
    if (PC !== 32'h14) begin errors++; $display("FAIL br_and_jmp: got %h want 14", PC); end
    checks++;
    pc_model = 32'h14;
  endtask

  task automatic test_timeout();
    IMEM_BUSYWAIT = 1'b1;
    repeat (14) step();
    if (FAULT !== 1'b0 || IMEM_READ !== 1'b1) begin
      errors++; $display("FAIL to_early: got fault=%b read=%b want 0/1", FAULT, IMEM_READ);
    end
    checks++;
    step();
    if (FAULT !== 1'b1 || IMEM_READ !== 1'b0 || INSTR_VALID !== 1'b0 || PC !== 32'h14) begin
      errors++; $display("FAIL to_fault: got fault=%b read=%b valid=%b pc=%h want 1/0/0/14",
                         FAULT, IMEM_READ, INSTR_VALID, PC);
    end
    checks++;
    IMEM_BUSYWAIT = 1'b0; DMEM_BUSYWAIT = 1'b0; JUMP = 1'b1; RD_OFFSET = 8'h10;
    repeat (4) step();
    JUMP = 1'b0;
    if (FAULT !== 1'b1 || IMEM_READ !== 1'b0 || PC !== 32'h14) begin
      errors++; $display("FAIL to_sticky: got fault=%b read=%b pc=%h want 1/0/14", FAULT, IMEM_READ, PC);
    end
    checks++;
    do_reset();
    if (FAULT !== 1'b0 || IMEM_READ !== 1'b1 || PC !== 32'h0) begin
      errors++; $display("FAIL to_clear: got fault=%b read=%b pc=%h want 0/1/0", FAULT, IMEM_READ, PC);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    IMEM_BUSYWAIT = 1'b1;
    step(); step();
    RESET = 1'b0;
    step();
    if (PC !== 32'h0 || {IMEM_READ, INSTR_VALID, FAULT} !== 3'b000 || INSTRUCTION !== 32'h0) begin
      errors++; $display("FAIL rst_fetch: got pc=%h flags=%b instr=%h want 0/000/0",
                         PC, {IMEM_READ, INSTR_VALID, FAULT}, INSTRUCTION);
    end
    checks++;
    RESET = 1'b1;
    step();
    fetch(0, 32'h7777_0000);
    DMEM_BUSYWAIT = 1'b1;
    step(); step();
    RESET = 1'b0;
    step();
    if (PC !== 32'h0 || {IMEM_READ, INSTR_VALID, FAULT} !== 3'b000 || INSTRUCTION !== 32'h0) begin
      errors++; $display("FAIL rst_stall: got pc=%h flags=%b instr=%h want 0/000/0",
                         PC, {IMEM_READ, INSTR_VALID, FAULT}, INSTRUCTION);
    end
    checks++;
    DMEM_BUSYWAIT = 1'b0;
    RESET = 1'b1;
    step();
    if (IMEM_READ !== 1'b1) begin errors++; $display("FAIL rst_resume: got read=%b want 1", IMEM_READ); end
    checks++;
  endtask

  task automatic test_wrap();
    fetch(0, 32'h8888_0000);
    commit(1'b0, 1'b1, 1'b0, 8'hFE);
    if (PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_back: got %h want fffffffc", PC); end
    checks++;
    fetch(0, 32'h9999_0000);
    commit(1'b0, 1'b0, 1'b0, 8'h00);
    if (PC !== 32'h0) begin errors++; $display("FAIL wrap_fwd: got %h want 0", PC); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_branch();
    test_jump();
    test_mem_stall();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
